// File: rtl/ariane_pkg.sv
// Shared frontend types: resolved-branch record from execute and the
// BHT prediction returned to fetch.
package ariane_pkg;

    localparam int unsigned BHT_ENTRIES = 64;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [63:0] target_address;
        logic        is_mispredict;
        logic        is_taken;
        logic        clear;
    } branchpredict_t;

    typedef struct packed {
        logic valid;
        logic taken;
    } bht_prediction_t;

endpackage

// File: rtl/bht.sv
// Branch history table: one 2-bit saturating counter per row, trained by
// resolved branches, read combinationally by fetch.
module bht
    import ariane_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = BHT_ENTRIES
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic [63:0]     vpc_i,
    input  branchpredict_t  resolved_branch_i,
    output bht_prediction_t bht_prediction_o
);

    localparam int unsigned IDX_BITS = $clog2(NR_ENTRIES);

    typedef struct packed {
        logic       valid;
        logic [1:0] saturation_counter;
    } bht_entry_t;

    bht_entry_t [NR_ENTRIES-1:0] bht_q;
    bht_entry_t [NR_ENTRIES-1:0] bht_d;

    logic [IDX_BITS-1:0] lookup_idx;
    logic [IDX_BITS-1:0] update_idx;
    bht_entry_t          lookup_entry;
    bht_entry_t          update_entry;

    // Only the row-select bits of the PCs matter; the rest is deliberately ignored.
    logic unused_bits;
    assign unused_bits = ^{vpc_i, resolved_branch_i};

    assign lookup_idx   = vpc_i[IDX_BITS+1:2];
    assign update_idx   = resolved_branch_i.pc[IDX_BITS+1:2];
    assign lookup_entry = bht_q[lookup_idx];
    assign update_entry = bht_q[update_idx];

    assign bht_prediction_o.valid = lookup_entry.valid;
    assign bht_prediction_o.taken = lookup_entry.valid
                                  & lookup_entry.saturation_counter[1];

    always_comb begin
        bht_d = bht_q;
        if (flush_i) begin
            bht_d = '0;
        end else if (resolved_branch_i.valid) begin
            if (resolved_branch_i.clear) begin
                bht_d[update_idx] = '0;
            end else if (!update_entry.valid) begin
                bht_d[update_idx].valid = 1'b1;
                bht_d[update_idx].saturation_counter =
                    resolved_branch_i.is_taken ? 2'd2 : 2'd1;
            end else if (resolved_branch_i.is_taken) begin
                if (update_entry.saturation_counter != 2'd3)
                    bht_d[update_idx].saturation_counter =
                        update_entry.saturation_counter + 2'd1;
            end else begin
                if (update_entry.saturation_counter != 2'd0)
                    bht_d[update_idx].saturation_counter =
                        update_entry.saturation_counter - 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bht_q <= '0;
        end else begin
            bht_q <= bht_d;
        end
    end

endmodule

// File: tb/tb_bht.sv
// Self-checking bench for bht: directed vector table, corner sequences,
// and randomized traffic against a counter-array reference model.
module tb_bht;
    import ariane_pkg::*;

    localparam int N = 64;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic [63:0]     vpc;
    branchpredict_t  rb;
    bht_prediction_t pred;

    int checks;
    int failures;

    // Reference model: per-row valid flag and integer counter 0..3.
    bit mv [N];
    int mc [N];

    bht #(.NR_ENTRIES(N)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .flush_i           (flush),
        .vpc_i             (vpc),
        .resolved_branch_i (rb),
        .bht_prediction_o  (pred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          uv;
        logic [63:0] pc;
        bit          tk;
        bit          cl;
        logic [63:0] lk;
        bit          ev;
        bit          et;
    } vec_t;

    vec_t vt[$];

    function automatic int row(input logic [63:0] pc);
        return int'((pc / 4) % N);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            mv[i] = 1'b0;
            mc[i] = 0;
        end
    endfunction

    function automatic void model_update(input bit v, input logic [63:0] pc,
                                         input bit tk, input bit cl,
                                         input bit fl);
        int r;
        r = row(pc);
        if (fl) begin
            model_reset();
        end else if (v) begin
            if (cl) begin
                mv[r] = 1'b0;
                mc[r] = 0;
            end else if (!mv[r]) begin
                mv[r] = 1'b1;
                mc[r] = tk ? 2 : 1;
            end else if (tk) begin
                mc[r] = (mc[r] < 3) ? mc[r] + 1 : 3;
            end else begin
                mc[r] = (mc[r] > 0) ? mc[r] - 1 : 0;
            end
        end
    endfunction

    task automatic check(input logic [63:0] pc, input bit ev, input bit et,
                         input string nm);
        vpc = pc;
        #1;
        checks++;
        if (pred.valid !== ev || pred.taken !== et) begin
            failures++;
            $display("FAIL %s pc=%h got {%b,%b} expected {%b,%b}",
                     nm, pc, pred.valid, pred.taken, ev, et);
        end
    endtask

    task automatic check_model(input logic [63:0] pc, input string nm);
        int r;
        r = row(pc);
        check(pc, mv[r], mv[r] && (mc[r] >= 2), nm);
    endtask

    task automatic cycle(input bit v, input logic [63:0] pc, input bit tk,
                         input bit cl, input bit fl);
        @(negedge clk);
        rb.valid    = v;
        rb.pc       = pc;
        rb.is_taken = tk;
        rb.clear    = cl;
        flush       = fl;
        @(posedge clk);
        #1;
        rb.valid = 1'b0;
        flush    = 1'b0;
        model_update(v, pc, tk, cl, fl);
    endtask

    function automatic void add(input bit uv, input logic [63:0] pc,
                                input bit tk, input bit cl,
                                input logic [63:0] lk, input bit ev,
                                input bit et);
        vec_t v;
        v.uv = uv; v.pc = pc; v.tk = tk; v.cl = cl;
        v.lk = lk; v.ev = ev; v.et = et;
        vt.push_back(v);
    endfunction

    initial begin
        logic [63:0] p;
        logic [63:0] q;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        vpc      = '0;
        rb       = '0;
        model_reset();

        // Training, saturation, aliasing and clear sequences.
        add(1, 64'h8000_0010, 1, 0, 64'h8000_0010, 1, 1);
        add(1, 64'h8000_0010, 1, 0, 64'h8000_0010, 1, 1);
        add(1, 64'h8000_0010, 1, 0, 64'h8000_0010, 1, 1);
        add(1, 64'h8000_0010, 0, 0, 64'h8000_0010, 1, 1);
        add(1, 64'h8000_0010, 0, 0, 64'h8000_0010, 1, 0);
        add(1, 64'h8000_0010, 0, 0, 64'h8000_0010, 1, 0);
        add(1, 64'h8000_0010, 0, 0, 64'h8000_0010, 1, 0);
        add(1, 64'h8000_0010, 1, 0, 64'h8000_0010, 1, 0);
        add(1, 64'h8000_0010, 1, 0, 64'h8000_0010, 1, 1);
        add(1, 64'h0000_1000, 1, 0, 64'h0000_1100, 1, 1);
        add(0, 64'h0000_1000, 0, 0, 64'h0000_1004, 0, 0);
        add(1, 64'h0000_2008, 1, 0, 64'h0000_2008, 1, 1);
        add(1, 64'h0000_2008, 1, 0, 64'h0000_2008, 1, 1);
        add(1, 64'h0000_2008, 1, 0, 64'h0000_2008, 1, 1);
        add(1, 64'h0000_2008, 1, 1, 64'h0000_2008, 0, 0);
        add(1, 64'h0000_2008, 0, 0, 64'h0000_2008, 1, 0);
        add(1, 64'h0000_2008, 1, 0, 64'h0000_2008, 1, 1);
        add(0, 64'h0000_2008, 0, 0, 64'h0000_1004, 0, 0);

        #12;
        check(64'h8000_0010, 0, 0, "reset_lookup");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++)
            check(64'(i * 4), 0, 0, "reset_row");

        for (int i = 0; i < vt.size(); i++) begin
            cycle(vt[i].uv, vt[i].pc, vt[i].tk, vt[i].cl, 1'b0);
            check(vt[i].lk, vt[i].ev, vt[i].et, $sformatf("vec%0d", i));
        end

        // Same-cycle lookup sees the pre-update value.
        @(negedge clk);
        rb.valid = 1'b1; rb.pc = 64'h4020; rb.is_taken = 1'b1; rb.clear = 1'b0;
        check(64'h4020, 0, 0, "same_cycle_pre");
        @(posedge clk);
        #1;
        rb.valid = 1'b0;
        model_update(1'b1, 64'h4020, 1'b1, 1'b0, 1'b0);
        check(64'h4020, 1, 1, "same_cycle_post");

        // Flush wins over a concurrent update.
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 64'h3000 + 64'(i * 4), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            check(64'h3000 + 64'(i * 4), 1, 1, "pre_flush");
        cycle(1'b1, 64'h3010, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++)
            check(64'h3000 + 64'(i * 4), 0, 0, "post_flush");

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            p = {32'($urandom), 32'($urandom)};
            q = {32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 3) == 0) p[7:2] = q[7:2];
            cycle($urandom_range(0, 3) != 0, p, 1'($urandom),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
            check_model(p, "rand_upd");
            check_model(q, "rand_lk");
        end

        // Asynchronous reset with trained rows, away from any clock edge.
        cycle(1'b1, 64'h8000_0010, 1'b1, 1'b0, 1'b0);
        check(64'h8000_0010, 1, 1, "pre_reset");
        #2;
        rst_n = 1'b0;
        model_reset();
        check(64'h8000_0010, 0, 0, "async_reset");
        for (int i = 0; i < N; i++)
            check({32'($urandom), 24'($urandom), 6'(i), 2'($urandom)},
                  0, 0, "reset_sweep");
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 64'h5000, 1'b0, 1'b0, 1'b0);
        check(64'h5000, 1, 0, "after_reset_init");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule

// File: doc/bht.md
# bht

Branch history table in the Ariane frontend, and the consumer of the resolved-branch record that the execute stage's branch unit emits. Each resolved branch trains a per-entry 2-bit saturating counter; an aliasing clear invalidates its entry. The fetch stage looks up the current fetch PC combinationally and gets a taken/not-taken prediction with a valid flag. A flush invalidates the whole table in one cycle.

## Interface
Parameters:
- NR_ENTRIES, 64: number of table rows; power of two, at least 4.

Ports:
- clk_i  in  1  core clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  invalidates all entries at the next edge.
- vpc_i  in  64  fetch PC to predict.
- resolved_branch_i  in  branchpredict_t  update from execute. Fields used: valid, pc, is_taken, clear.
- bht_prediction_o  out  bht_prediction_t  {valid, taken} for vpc_i.

## Operation
- Index width IDX_BITS = $clog2(NR_ENTRIES).
- Lookup index = vpc_i[IDX_BITS+1:2]; update index = resolved_branch_i.pc[IDX_BITS+1:2]. Bits [1:0] and the upper bits are ignored, so aliasing is accepted.
- Each entry holds valid (1 bit) and saturation_counter (2 bits, 0..3).
- Lookup is purely combinational:
  - bht_prediction_o.valid = entry.valid.
  - bht_prediction_o.taken = entry.valid & counter[1].
- An update fires when resolved_branch_i.valid = 1. Update rules, in priority order:
  - flush_i = 1: every entry goes to valid=0, counter=0. Any concurrent update is dropped.
  - clear = 1: the indexed entry goes to valid=0, counter=0. is_taken is ignored.
  - Entry invalid: set valid=1, and counter = 2 if is_taken, else 1 (weak taken / weak not-taken).
  - Entry valid and is_taken: counter increments, saturating at 3.
  - Entry valid and !is_taken: counter decrements, saturating at 0.
- Only the indexed entry changes on an update. All other entries hold their state.
- The table has no state machine. State is the entry array only.

## Timing
- Reset: all entries are valid=0, counter=0, so bht_prediction_o = {0,0} for every vpc_i.
- Lookup latency is 0 cycles: the output follows vpc_i within the same cycle.
- Update latency: state is written at the rising edge that samples resolved_branch_i.valid. It is visible to lookups from the following cycle.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update value. There is no bypass.
- Flush is single-cycle. The cycle after flush_i, all lookups return {0,0}.
- An update arriving together with flush_i is lost and is not replayed.
- Reset asserted mid-operation clears the array asynchronously. Outputs go to {0,0} immediately, independent of the clock.
- There is no handshake. An update is always accepted (ready is implicitly 1).

## Structure
- In ariane_pkg:
  - typedef bht_prediction_t {logic valid; logic taken;}.
  - Default parameter constant BHT_ENTRIES = 64.
- Local to this module: the entry struct {logic valid; logic [1:0] saturation_counter;}.
- Sub-module: none. The counter update is a small always_comb next-state block feeding one always_ff array with asynchronous reset.

## Test plan
- **Reset:** assert rst_ni=0 mid-run with trained entries, then sweep vpc_i over 64 rows -> every lookup returns {0,0}.
- **Training:** update pc=0x80000010 with is_taken=1 three times -> after the first, counter=2 and lookup of 0x80000010 gives {1,1}; after the third, counter=3. Then three !is_taken updates -> counter 2, 1, 0, with lookup taken=0 from counter=1 onward.
- **Aliasing:** train pc=0x1000 taken, then look up 0x1100 (same index with NR_ENTRIES=64) -> {1,1}. Look up 0x1004 -> {0,0}.
- **Clear:** train pc=0x2008 to counter=3, then update with clear=1 and is_taken=1 -> next cycle lookup returns {0,0}. A later !is_taken update initializes counter=1.
- **Flush priority:** train 4 distinct rows, then pulse flush_i together with a taken update to a fifth row -> all 5 rows return {0,0} the next cycle.
- **Same-cycle read/write:** vpc_i = pc of an update to an invalid entry in cycle N -> {0,0} in N, {1,1} in N+1.
